// File: rtl/fe_batch_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : fe_batch_dispatcher
// Description : Custom-instruction front end for the function-evaluation
//               datapath. Decodes n = CLEAR/GO/READ/STATUS, buffers GO operand
//               pairs in a FIFO, issues them downstream over valid/ready,
//               tracks pairs in flight, and drains the pipeline before
//               READ/CLEAR respond.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst           clock / synchronous active-low reset
//   clk_en, start, n   command strobe (qualified by clk_en) and command code
//   x_one, x_two       GO operands
//   result, done       command result and one-cycle completion pulse
//   issue_*            FIFO head towards the pipeline (valid/ready)
//   retire, acc_total  pair-retired strobe and accumulated total from stage 4
//   clear_acc          one-cycle pulse zeroing the downstream accumulators
//   busy               command in progress
// Configuration
//   FE_DRAIN_TIMEOUT_EN  when defined, DRAIN gives up after DRAIN_TIMEOUT
//                        cycles, answers qNaN and flushes FIFO/in-flight.
// ============================================================================
module fe_batch_dispatcher #(
    parameter int FLT_DATA_WIDTH = 32,
    parameter int N_WIDTH        = 2,
    parameter int FIFO_DEPTH     = 4,
    parameter int INFLIGHT_MAX   = 8,
    parameter int CNT_WIDTH      = 4,
    parameter int DRAIN_TIMEOUT  = 1023
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clk_en,
    input  logic                      start,
    input  logic [N_WIDTH-1:0]        n,
    input  logic [FLT_DATA_WIDTH-1:0] x_one,
    input  logic [FLT_DATA_WIDTH-1:0] x_two,
    output logic [FLT_DATA_WIDTH-1:0] result,
    output logic                      done,
    output logic                      issue_valid,
    input  logic                      issue_ready,
    output logic [FLT_DATA_WIDTH-1:0] issue_x_one,
    output logic [FLT_DATA_WIDTH-1:0] issue_x_two,
    input  logic                      retire,
    input  logic [FLT_DATA_WIDTH-1:0] acc_total,
    output logic                      clear_acc,
    output logic                      busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ENQUEUE = 2'd1;
    localparam logic [1:0] S_DRAIN   = 2'd2;
    localparam logic [1:0] S_RESPOND = 2'd3;

    localparam logic [N_WIDTH-1:0] CMD_CLEAR  = N_WIDTH'(0);
    localparam logic [N_WIDTH-1:0] CMD_GO     = N_WIDTH'(1);
    localparam logic [N_WIDTH-1:0] CMD_READ   = N_WIDTH'(2);
    localparam logic [N_WIDTH-1:0] CMD_STATUS = N_WIDTH'(3);

    logic [1:0]                state_q, state_d;
    logic [FLT_DATA_WIDTH-1:0] result_q;
    logic                      done_q;
    logic                      clear_acc_q;
    logic                      is_clear_q;
    logic [FLT_DATA_WIDTH-1:0] pend_one_q, pend_two_q;

    logic [FLT_DATA_WIDTH-1:0] mem_one_q [FIFO_DEPTH];
    logic [FLT_DATA_WIDTH-1:0] mem_two_q [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_q, rd_ptr_q;
    logic [CNT_WIDTH-1:0]      fifo_cnt_q, fifo_cnt_d;
    logic [CNT_WIDTH-1:0]      inflight_q, inflight_d;

    logic                      w_accept, w_full, w_empty, w_push, w_pop;
    logic                      w_ret, w_drained, w_timeout;
    logic [FLT_DATA_WIDTH-1:0] w_push_one, w_push_two;

    assign w_accept  = (state_q == S_IDLE) && start && clk_en;
    assign w_full    = (fifo_cnt_q == CNT_WIDTH'(FIFO_DEPTH));
    assign w_empty   = (fifo_cnt_q == '0);
    assign w_drained = w_empty && (inflight_q == '0);

    // Fullness is judged on the pre-pop count, so a stalled GO always
    // lands one cycle after the pop that frees its slot.
    assign w_push = !w_full && ((state_q == S_ENQUEUE) ||
                                (w_accept && (n == CMD_GO)));
    assign w_push_one = (state_q == S_ENQUEUE) ? pend_one_q : x_one;
    assign w_push_two = (state_q == S_ENQUEUE) ? pend_two_q : x_two;

    assign issue_valid = !w_empty && (inflight_q < CNT_WIDTH'(INFLIGHT_MAX));
    assign issue_x_one = mem_one_q[rd_ptr_q];
    assign issue_x_two = mem_two_q[rd_ptr_q];
    assign w_pop       = issue_valid && issue_ready;
    // A retire with nothing in flight is spurious and dropped.
    assign w_ret       = retire && (inflight_q != '0);

`ifdef FE_DRAIN_TIMEOUT_EN
    localparam int TO_W = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [TO_W-1:0]           TO_LAST = TO_W'(DRAIN_TIMEOUT - 1);
    localparam logic [FLT_DATA_WIDTH-1:0] QNAN    = FLT_DATA_WIDTH'(32'h7FC0_0000);

    logic [TO_W-1:0] to_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            to_cnt_q <= '0;
        end else if (state_q == S_DRAIN) begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
        end else begin
            to_cnt_q <= '0;
        end
    end

    // Fires on the DRAIN_TIMEOUT-th drain cycle unless draining finished.
    assign w_timeout = (state_q == S_DRAIN) && !w_drained && (to_cnt_q == TO_LAST);
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (DRAIN_TIMEOUT > 0);
    assign w_timeout        = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    case (n)
                        CMD_GO:              state_d = w_full ? S_ENQUEUE : S_IDLE;
                        CMD_READ, CMD_CLEAR: state_d = S_DRAIN;
                        default:             state_d = S_IDLE;
                    endcase
                end
            end
            S_ENQUEUE: if (!w_full) state_d = S_IDLE;
            S_DRAIN:   if (w_drained || w_timeout) state_d = S_RESPOND;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        if (w_push && !w_pop) begin
            fifo_cnt_d = fifo_cnt_q + CNT_WIDTH'(1);
        end else if (!w_push && w_pop) begin
            fifo_cnt_d = fifo_cnt_q - CNT_WIDTH'(1);
        end
        inflight_d = inflight_q;
        if (w_pop && !w_ret) begin
            inflight_d = inflight_q + CNT_WIDTH'(1);
        end else if (!w_pop && w_ret) begin
            inflight_d = inflight_q - CNT_WIDTH'(1);
        end
    end

    // Command sequencing and the registered result/done/clear_acc outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            result_q    <= '0;
            done_q      <= 1'b0;
            clear_acc_q <= 1'b0;
            is_clear_q  <= 1'b0;
            pend_one_q  <= '0;
            pend_two_q  <= '0;
        end else begin
            state_q     <= state_d;
            done_q      <= 1'b0;
            clear_acc_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (w_accept) begin
                        case (n)
                            CMD_GO: begin
                                if (w_full) begin
                                    pend_one_q <= x_one;
                                    pend_two_q <= x_two;
                                end else begin
                                    done_q   <= 1'b1;
                                    result_q <= '0;
                                end
                            end
                            CMD_STATUS: begin
                                done_q   <= 1'b1;
                                result_q <= FLT_DATA_WIDTH'({fifo_cnt_q, inflight_q});
                            end
                            CMD_READ, CMD_CLEAR: is_clear_q <= (n == CMD_CLEAR);
                            default: ;
                        endcase
                    end
                end
                S_ENQUEUE: begin
                    if (!w_full) begin
                        done_q   <= 1'b1;
                        result_q <= '0;
                    end
                end
                S_DRAIN: begin
                    // done is raised on entry to RESPOND so it is visible
                    // during the RESPOND cycle itself.
                    if (w_drained) begin
                        done_q      <= 1'b1;
                        result_q    <= is_clear_q ? '0 : acc_total;
                        clear_acc_q <= is_clear_q;
                    end
`ifdef FE_DRAIN_TIMEOUT_EN
                    else if (w_timeout) begin
                        done_q   <= 1'b1;
                        result_q <= QNAN;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    // FIFO pointers and counters keep running independent of clk_en.
    always_ff @(posedge clk) begin
        if (!rst || w_timeout) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            inflight_q <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (w_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            fifo_cnt_q <= fifo_cnt_d;
            inflight_q <= inflight_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_one_q[wr_ptr_q] <= w_push_one;
            mem_two_q[wr_ptr_q] <= w_push_two;
        end
    end

    assign result    = result_q;
    assign done      = done_q;
    assign clear_acc = clear_acc_q;
    assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire
